// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among functional units, registered broadcast
// of the winner's label/data, and a saturating broadcast counter.
module cdb_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LABEL_W = 4
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*LABEL_W-1:0]   req_label,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic                      flush,
    output logic [NREQ-1:0]           req_grant,
    output logic                      BCEN,
    output logic [LABEL_W-1:0]        BClabel,
    output logic [DATA_W-1:0]         BCdata,
    output logic [15:0]               bc_count
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PtrW-1:0]    rr_ptr_q;
    logic [PtrW-1:0]    win;
    logic [PtrW-1:0]    idx;
    logic               found;
    logic [LABEL_W-1:0] win_label;
    logic [DATA_W-1:0]  win_data;
    logic               bcen_d;

    // Grant depends only on valid/flush/reset/pointer, never on label or data.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        if (nRST && !flush) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = PtrW'((int'(rr_ptr_q) + k) % int'(NREQ));
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        req_grant = found ? (NREQ'(1) << win) : '0;
    end

    assign win_label = req_label[win*LABEL_W +: LABEL_W];
    assign win_data  = req_data[win*DATA_W +: DATA_W];
    // A label-0 transfer still consumes the grant but broadcasts nothing.
    assign bcen_d    = found && (win_label != '0);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            rr_ptr_q <= '0;
            BCEN     <= 1'b0;
            BClabel  <= '0;
            BCdata   <= '0;
            bc_count <= '0;
        end else begin
            if (found) begin
                rr_ptr_q <= (win == PtrW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            BCEN    <= bcen_d;
            BClabel <= bcen_d ? win_label : '0;
            BCdata  <= bcen_d ? win_data : '0;
            if (bcen_d && (bc_count != 16'hFFFF)) begin
                bc_count <= bc_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_cdb_arbiter;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;

    logic                    clk = 1'b0;
    logic                    nRST;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*LABEL_W-1:0] req_label;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic                    flush;
    logic [NREQ-1:0]         req_grant;
    logic                    BCEN;
    logic [LABEL_W-1:0]      BClabel;
    logic [DATA_W-1:0]       BCdata;
    logic [15:0]             bc_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_rr;
    int unsigned m_count;
    logic        m_bcen;
    logic [3:0]  m_label;
    logic [31:0] m_data;

    cdb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_label (req_label),
        .req_data  (req_data),
        .flush     (flush),
        .req_grant (req_grant),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .bc_count  (bc_count)
    );

    always #5 clk = ~clk;

    // First valid requester scanning from the model pointer; -1 if none may win.
    function automatic int m_winner();
        if (!nRST || flush) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant();
        int w;
        w = m_winner();
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick(output int w);
        logic [3:0] lbl;
        w = m_winner();
        @(posedge clk);
        if (!nRST) begin
            m_rr = 0; m_count = 0; m_bcen = 1'b0; m_label = '0; m_data = '0;
        end else if (w >= 0) begin
            m_rr = (w + 1) % NREQ;
            lbl  = req_label[w*LABEL_W +: LABEL_W];
            if (lbl != 0) begin
                m_bcen = 1'b1; m_label = lbl; m_data = req_data[w*DATA_W +: DATA_W];
                if (m_count < 32'hFFFF) m_count++;
            end else begin
                m_bcen = 1'b0; m_label = '0; m_data = '0;
            end
        end else begin
            m_bcen = 1'b0; m_label = '0; m_data = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        int w;
        nRST = 1'b0; flush = 1'b0; req_valid = 4'b1111;
        req_label = 16'h4321; req_data = {4{32'hA5A5_5A5A}};
        #1;
        checks++;
        if (req_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant: got %b want 0000", req_grant);
        end
        tick(w); tick(w);
        checks++;
        if (BCEN !== 1'b0 || BClabel !== 4'd0 || BCdata !== 32'd0 || bc_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b lbl=%0d data=%h cnt=%0d want all zero",
                     BCEN, BClabel, BCdata, bc_count);
        end
        req_valid = 4'b0000; nRST = 1'b1;
        tick(w);
    endtask

    task automatic test_basic_pair();
        int w;
        req_valid = 4'b1010;
        req_label = {4'd5, 4'd0, 4'd3, 4'd0};
        req_data  = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0};
        #1;
        checks++;
        if (req_grant !== 4'b0010) begin
            errors++; $display("FAIL pair_grant1: got %b want 0010", req_grant);
        end
        tick(w);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (BCEN !== 1'b1 || BClabel !== 4'd3 || BCdata !== 32'h1111_0001) begin
            errors++;
            $display("FAIL pair_bc1: got en=%b lbl=%0d data=%h want 1/3/11110001",
                     BCEN, BClabel, BCdata);
        end
        checks++;
        if (req_grant !== 4'b1000) begin
            errors++; $display("FAIL pair_grant2: got %b want 1000", req_grant);
        end
        tick(w);
        req_valid = 4'b0000;
        checks++;
        if (BCEN !== 1'b1 || BClabel !== 4'd5 || bc_count !== 16'd2) begin
            errors++;
            $display("FAIL pair_bc2: got en=%b lbl=%0d cnt=%0d want 1/5/2", BCEN, BClabel, bc_count);
        end
        tick(w);
        checks++;
        if (BCEN !== 1'b0 || BClabel !== 4'd0 || BCdata !== 32'd0) begin
            errors++;
            $display("FAIL idle_bc: got en=%b lbl=%0d data=%h want zeros", BCEN, BClabel, BCdata);
        end
    endtask

    task automatic test_round_robin();
        int w;
        req_valid = 4'b1111;
        req_label = {4'd4, 4'd3, 4'd2, 4'd1};
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (req_grant !== m_grant()) begin
                errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_grant, m_grant());
            end
            tick(w);
            checks++;
            if (BCEN !== 1'b1 || BClabel !== 4'((c % 4) + 1) || BCdata !== m_data) begin
                errors++;
                $display("FAIL rr_bc c%0d: got en=%b lbl=%0d data=%h want 1/%0d/%h",
                         c, BCEN, BClabel, BCdata, (c % 4) + 1, m_data);
            end
        end
        req_valid = 4'b0000;
        tick(w);
    endtask

    task automatic test_flush();
        int w;
        req_valid = 4'b0001; req_label = 16'h0009; req_data = {96'h0, 32'hCAFE_0009};
        tick(w);  // transfer, then flush while it is on the outputs
        flush = 1'b1;
        #1;
        checks++;
        if (BCEN !== 1'b1 || BClabel !== 4'd9) begin
            errors++; $display("FAIL flush_keep: got en=%b lbl=%0d want 1/9", BCEN, BClabel);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (req_grant !== 4'b0000) begin
                errors++; $display("FAIL flush_grant c%0d: got %b want 0000", c, req_grant);
            end
            tick(w);
            checks++;
            if (BCEN !== 1'b0) begin
                errors++; $display("FAIL flush_bc c%0d: got en=%b want 0", c, BCEN);
            end
        end
        flush = 1'b0; req_label = 16'h0007;
        #1;
        checks++;
        if (req_grant !== 4'b0001) begin
            errors++; $display("FAIL flush_after_grant: got %b want 0001", req_grant);
        end
        tick(w);
        req_valid = 4'b0000;
        checks++;
        if (BCEN !== 1'b1 || BClabel !== 4'd7) begin
            errors++; $display("FAIL flush_after_bc: got en=%b lbl=%0d want 1/7", BCEN, BClabel);
        end
        tick(w);
    endtask

    task automatic test_label_zero();
        int w;
        int unsigned cnt0;
        cnt0 = m_count;
        req_valid = 4'b0001; req_label = 16'h0000; req_data = {96'h0, 32'hDEAD_BEEF};
        #1;
        checks++;
        if (req_grant !== 4'b0001) begin
            errors++; $display("FAIL lz_grant: got %b want 0001", req_grant);
        end
        tick(w);
        checks++;
        if (BCEN !== 1'b0 || BCdata !== 32'd0 || BClabel !== 4'd0 || bc_count !== 16'(cnt0)) begin
            errors++;
            $display("FAIL lz_bc: got en=%b data=%h cnt=%0d want 0/0/%0d", BCEN, BCdata, bc_count, cnt0);
        end
        // Pointer must now sit at 1: with 0 and 1 valid, 1 wins.
        req_valid = 4'b0011; req_label = 16'h00A6;
        #1;
        checks++;
        if (req_grant !== 4'b0010) begin
            errors++; $display("FAIL lz_ptr: got %b want 0010", req_grant);
        end
        req_valid = 4'b0000;
        tick(w);
    endtask

    task automatic test_reset_mid();
        int w;
        req_valid = 4'b0100; req_label = 16'h0B00; req_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if (req_grant !== 4'b0100) begin
            errors++; $display("FAIL rst_mid_pre: got %b want 0100", req_grant);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (req_grant !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_grant: got %b want 0000", req_grant);
        end
        tick(w);
        checks++;
        if (BCEN !== 1'b0 || bc_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid_bc: got en=%b cnt=%0d want 0/0", BCEN, bc_count);
        end
        nRST = 1'b1; req_valid = 4'b0111; req_label = 16'h0321;
        #1;
        checks++;
        if (req_grant !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_first: got %b want 0001", req_grant);
        end
        req_valid = 4'b0000;
        tick(w);
    endtask

    task automatic test_random();
        int w;
        w = -1;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            // Requesters hold label/data until granted, then may issue a fresh result.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || w == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_label[i*LABEL_W +: LABEL_W] = 4'($urandom_range(0, 15));
                    req_data[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            flush = ($urandom_range(0, 7) == 0);
            nRST  = ($urandom_range(0, 49) != 0);
            #1;
            checks++;
            if (req_grant !== m_grant()) begin
                errors++; $display("FAIL rnd_grant c%0d: got %b want %b", c, req_grant, m_grant());
            end
            tick(w);
            checks++;
            if (BCEN !== m_bcen || BClabel !== m_label || BCdata !== m_data ||
                bc_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL rnd_bc c%0d: got %b/%0d/%h/%0d want %b/%0d/%h/%0d", c, BCEN, BClabel,
                         BCdata, bc_count, m_bcen, m_label, m_data, m_count);
            end
        end
        nRST = 1'b1; flush = 1'b0; req_valid = '0;
        tick(w);
    endtask

    task automatic test_saturation();
        int w;
        req_valid = 4'b1111; req_label = 16'h4321; req_data = {$urandom, $urandom, $urandom, $urandom};
        while (m_count < 32'hFFFE) tick(w);
        checks++;
        if (bc_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_fffe: got %h want fffe", bc_count);
        end
        tick(w);
        checks++;
        if (bc_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_ffff: got %h want ffff", bc_count);
        end
        tick(w); tick(w); tick(w);
        checks++;
        if (bc_count !== 16'hFFFF || BCEN !== 1'b1) begin
            errors++; $display("FAIL sat_hold: got cnt=%h en=%b want ffff/1", bc_count, BCEN);
        end
        req_valid = '0;
    endtask

    initial begin
        m_rr = 0; m_count = 0; m_bcen = 1'b0; m_label = '0; m_data = '0;
        test_reset();
        test_basic_pair();
        test_round_robin();
        test_flush();
        test_label_zero();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of functional-unit requesters sharing the broadcast bus.
REQ-002 Parameter DATA_W, default 32: broadcast data width.
REQ-003 Parameter LABEL_W, default 4: reservation-station label width; label 0 means "no producer".
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NREQ  requester i has a result pending.
REQ-007 req_label  input  NREQ*LABEL_W  packed labels; requester i at bits [i*LABEL_W +: LABEL_W].
REQ-008 req_data  input  NREQ*DATA_W  packed results; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 flush  input  1  suppresses all grants this cycle (mispredict/kill).
REQ-010 req_grant  output  NREQ  combinational one-hot grant (ready) to requesters.
REQ-011 BCEN  output  1  registered broadcast enable to register file and reservation stations.
REQ-012 BClabel  output  LABEL_W  registered broadcast label.
REQ-013 BCdata  output  DATA_W  registered broadcast data.
REQ-014 bc_count  output  16  registered count of broadcasts issued, saturating.

Function
REQ-015 req_grant SHALL have at most one bit set in any cycle, and zero when no req_valid bit is set, flush=1, or nRST=0.
REQ-016 Winner SHALL be the first valid requester in order rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ; rr_ptr is internal, ceil(log2 NREQ) bits.
REQ-017 Transfer occurs at a rising edge where req_valid[i] & req_grant[i]; requester SHALL hold valid/label/data stable until then; arbiter never grants a non-valid requester.
REQ-018 Latency: on a transfer at edge t, BCEN/BClabel/BCdata SHALL show the winner's label/data during cycle t+1 (one cycle).
REQ-019 Cycles with no transfer SHALL produce BCEN=0, BClabel=0, BCdata=0 in the following cycle.
REQ-020 Throughput: one broadcast per cycle; back-to-back transfers from different or same requesters SHALL be supported with no bubble.
REQ-021 After a transfer by requester i, rr_ptr SHALL become (i+1) mod NREQ; without a transfer rr_ptr SHALL hold.
REQ-022 Fairness: a continuously valid requester SHALL be granted within NREQ cycles with flush=0.
REQ-023 Transfer with label 0 SHALL complete (grant, rr_ptr advances) but produce BCEN=0, BClabel=0, BCdata=0 next cycle and not increment bc_count.
REQ-024 flush=1 SHALL force no transfer, leave rr_ptr unchanged, and yield BCEN=0 next cycle; the broadcast already on outputs during the flush cycle is unaffected.
REQ-025 bc_count SHALL increment by 1 at each edge loading BCEN=1 and saturate at 16'hFFFF.
REQ-026 Arbitration SHALL be purely a function of current req_valid, flush, nRST and rr_ptr; no combinational path from req_data/req_label to req_grant.

Reset
REQ-027 At an edge with nRST=0: BCEN=0, BClabel=0, BCdata=0, bc_count=0, rr_ptr=0; no transfer occurs.
REQ-028 While nRST=0, req_grant SHALL be all zero; reset mid-transfer discards the pending winner, and the first post-reset grant starts from requester 0.

Verification
REQ-029 Reset then req_valid=4'b1010, labels 3 (req1) and 5 (req3) -> cycle1 grant=0010; next cycle BCEN=1, BClabel=3; then grant=1000, BClabel=5; bc_count=2.
REQ-030 All four valid continuously, labels 1..4 -> BClabel sequence 1,2,3,4,1,... back-to-back with BCEN=1 every cycle.
REQ-031 req_valid=0001 with flush=1 for 2 cycles, then flush=0 -> grant=0000 and BCEN=0 during flush; grant=0001 after, BClabel=req0 label.
REQ-032 req0 valid with label 0, data 32'hDEADBEEF -> grant=0001, next cycle BCEN=0, BCdata=0, bc_count unchanged, rr_ptr=1.
REQ-033 nRST=0 asserted in the cycle req2 is granted -> next cycle BCEN=0, bc_count=0; after release with 0111 valid -> grant=0001 first.
REQ-034 Force bc_count to 16'hFFFE via 2 + further broadcasts (or preload in sim) -> count stops at 16'hFFFF.
